// File: rtl/core_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | core_ctrl_fsm                                                              |
// | Multi-cycle sequencer: fetch, IR latch, execute, LSU, writeback, counters. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module core_ctrl_fsm #(
  parameter int TIMEOUT   = 256,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  output logic                 ifu_req_valid_o,
  input  logic                 ifu_req_ready_i,
  input  logic                 ifu_rsp_valid_i,
  input  logic                 ifu_rsp_err_i,
  output logic                 ir_wen_o,
  input  logic                 is_load_i,
  input  logic                 is_store_i,
  input  logic                 has_rd_i,
  input  logic                 ebreak_i,
  output logic                 lsu_req_valid_o,
  input  logic                 lsu_req_ready_i,
  input  logic                 lsu_rsp_valid_i,
  input  logic                 lsu_rsp_err_i,
  output logic                 rf_wen_o,
  output logic                 pc_wen_o,
  output logic                 retire_o,
  output logic                 halt_o,
  output logic                 err_o,
  output logic [1:0]           err_code_o,
  output logic [CNT_WIDTH-1:0] cycle_cnt_o,
  output logic [CNT_WIDTH-1:0] instret_cnt_o
);

  localparam logic [3:0] S_RESET      = 4'd0;
  localparam logic [3:0] S_FETCH_REQ  = 4'd1;
  localparam logic [3:0] S_FETCH_WAIT = 4'd2;
  localparam logic [3:0] S_EXEC       = 4'd3;
  localparam logic [3:0] S_MEM_REQ    = 4'd4;
  localparam logic [3:0] S_MEM_WAIT   = 4'd5;
  localparam logic [3:0] S_WB         = 4'd6;
  localparam logic [3:0] S_HALT       = 4'd7;
  localparam logic [3:0] S_ERROR      = 4'd8;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_FETCH = 2'd1;
  localparam logic [1:0] ERR_LSU   = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;

  localparam int              WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [3:0]           state_q, state_d;
  logic [1:0]           err_code_q, err_code_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_WIDTH-1:0] instret_cnt_q, instret_cnt_d;
  logic                 in_wait;
  logic                 tmo_hit;

  assign tmo_hit = (TIMEOUT != 0) && (wait_cnt_q == TMO_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_RESET;
      err_code_q    <= ERR_NONE;
      wait_cnt_q    <= '0;
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      err_code_q    <= err_code_d;
      wait_cnt_q    <= wait_cnt_d;
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  // A handshake arriving on the last allowed wait cycle beats the timeout.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    in_wait    = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH_REQ;
      S_FETCH_REQ: begin
        in_wait = 1'b1;
        if (ifu_req_ready_i) begin
          state_d = S_FETCH_WAIT;
        end else if (tmo_hit) begin
          state_d    = S_ERROR;
          err_code_d = ERR_TMO;
        end
      end
      S_FETCH_WAIT: begin
        in_wait = 1'b1;
        if (ifu_rsp_valid_i) begin
          if (ifu_rsp_err_i) begin
            state_d    = S_ERROR;
            err_code_d = ERR_FETCH;
          end else begin
            state_d = S_EXEC;
          end
        end else if (tmo_hit) begin
          state_d    = S_ERROR;
          err_code_d = ERR_TMO;
        end
      end
      S_EXEC: begin
        if (ebreak_i)                   state_d = S_HALT;
        else if (is_load_i | is_store_i) state_d = S_MEM_REQ;
        else                            state_d = S_WB;
      end
      S_MEM_REQ: begin
        in_wait = 1'b1;
        if (lsu_req_ready_i) begin
          state_d = S_MEM_WAIT;
        end else if (tmo_hit) begin
          state_d    = S_ERROR;
          err_code_d = ERR_TMO;
        end
      end
      S_MEM_WAIT: begin
        in_wait = 1'b1;
        if (lsu_rsp_valid_i) begin
          if (lsu_rsp_err_i) begin
            state_d    = S_ERROR;
            err_code_d = ERR_LSU;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_hit) begin
          state_d    = S_ERROR;
          err_code_d = ERR_TMO;
        end
      end
      S_WB:    state_d = S_FETCH_REQ;
      S_HALT:  state_d = S_HALT;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_RESET;
    endcase
  end

  always_comb begin
    ifu_req_valid_o = 1'b0;
    ir_wen_o        = 1'b0;
    lsu_req_valid_o = 1'b0;
    rf_wen_o        = 1'b0;
    pc_wen_o        = 1'b0;
    retire_o        = 1'b0;
    halt_o          = 1'b0;
    err_o           = 1'b0;
    case (state_q)
      S_FETCH_REQ:  ifu_req_valid_o = 1'b1;
      S_FETCH_WAIT: ir_wen_o        = ifu_rsp_valid_i & ~ifu_rsp_err_i;
      S_EXEC:       retire_o        = ebreak_i;
      S_MEM_REQ:    lsu_req_valid_o = 1'b1;
      S_WB: begin
        pc_wen_o = 1'b1;
        retire_o = 1'b1;
        rf_wen_o = has_rd_i & ~is_store_i;
      end
      S_HALT:  halt_o = 1'b1;
      S_ERROR: err_o  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    wait_cnt_d    = (in_wait && (state_d == state_q)) ? wait_cnt_q + 1'b1 : '0;
    cycle_cnt_d   = cycle_cnt_q;
    instret_cnt_d = instret_cnt_q;
    if ((state_q != S_RESET) && (state_q != S_HALT) && (state_q != S_ERROR))
      cycle_cnt_d = cycle_cnt_q + 1'b1;
    if (retire_o)
      instret_cnt_d = instret_cnt_q + 1'b1;
  end

  assign err_code_o    = err_code_q;
  assign cycle_cnt_o   = cycle_cnt_q;
  assign instret_cnt_o = instret_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_core_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_core_ctrl_fsm                                                           |
// | Directed vector table plus hand sequences for the core sequencer.          |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_core_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, ir_wen;
  logic        is_load, is_store, has_rd, ebreak;
  logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
  logic        rf_wen, pc_wen, retire, halt, err;
  logic [1:0]  err_code;
  logic [31:0] cycle_cnt, instret_cnt;
  logic [7:0]  outs;

  int checks   = 0;
  int failures = 0;

  // input bits : ifu_rdy ifu_rsp ifu_err ld st rd ebreak lsu_rdy lsu_rsp lsu_err
  // output bits: ifu_req ir_wen lsu_req rf_wen pc_wen retire halt err
  typedef struct {
    logic [9:0] in_bits;
    logic [7:0] exp_outs;
    int         exp_cyc;
    int         exp_ins;
  } vec_t;

  vec_t vecs[26];

  core_ctrl_fsm #(.TIMEOUT(8), .CNT_WIDTH(32)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .ifu_req_valid_o (ifu_req_valid),
    .ifu_req_ready_i (ifu_req_ready),
    .ifu_rsp_valid_i (ifu_rsp_valid),
    .ifu_rsp_err_i   (ifu_rsp_err),
    .ir_wen_o        (ir_wen),
    .is_load_i       (is_load),
    .is_store_i      (is_store),
    .has_rd_i        (has_rd),
    .ebreak_i        (ebreak),
    .lsu_req_valid_o (lsu_req_valid),
    .lsu_req_ready_i (lsu_req_ready),
    .lsu_rsp_valid_i (lsu_rsp_valid),
    .lsu_rsp_err_i   (lsu_rsp_err),
    .rf_wen_o        (rf_wen),
    .pc_wen_o        (pc_wen),
    .retire_o        (retire),
    .halt_o          (halt),
    .err_o           (err),
    .err_code_o      (err_code),
    .cycle_cnt_o     (cycle_cnt),
    .instret_cnt_o   (instret_cnt)
  );

  always #5 clk = ~clk;

  assign outs = {ifu_req_valid, ir_wen, lsu_req_valid, rf_wen, pc_wen, retire, halt, err};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic [9:0] v);
    {ifu_req_ready, ifu_rsp_valid, ifu_rsp_err, is_load, is_store, has_rd, ebreak,
     lsu_req_ready, lsu_rsp_valid, lsu_rsp_err} = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after an edge with the DUT sitting in RESET.
  task automatic do_reset();
    apply(10'b0);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{10'b0000000000, 8'b00000000,  0, 0};
    vecs[1]  = '{10'b1000000000, 8'b10000000,  0, 0};
    vecs[2]  = '{10'b0100000000, 8'b01000000,  1, 0};
    vecs[3]  = '{10'b0000010000, 8'b00000000,  2, 0};
    vecs[4]  = '{10'b0000010000, 8'b00011100,  3, 0};
    vecs[5]  = '{10'b1000000000, 8'b10000000,  4, 1};
    vecs[6]  = '{10'b0100000000, 8'b01000000,  5, 1};
    vecs[7]  = '{10'b0000100000, 8'b00000000,  6, 1};
    vecs[8]  = '{10'b0000100100, 8'b00100000,  7, 1};
    vecs[9]  = '{10'b0000100010, 8'b00000000,  8, 1};
    vecs[10] = '{10'b0000110000, 8'b00001100,  9, 1};
    vecs[11] = '{10'b0000000000, 8'b10000000, 10, 2};
    vecs[12] = '{10'b1000000000, 8'b10000000, 11, 2};
    vecs[13] = '{10'b0000000000, 8'b00000000, 12, 2};
    vecs[14] = '{10'b0100000000, 8'b01000000, 13, 2};
    vecs[15] = '{10'b0001000000, 8'b00000000, 14, 2};
    vecs[16] = '{10'b0001000000, 8'b00100000, 15, 2};
    vecs[17] = '{10'b0001000100, 8'b00100000, 16, 2};
    vecs[18] = '{10'b0001000000, 8'b00000000, 17, 2};
    vecs[19] = '{10'b0001000010, 8'b00000000, 18, 2};
    vecs[20] = '{10'b0001010000, 8'b00011100, 19, 2};
    vecs[21] = '{10'b1100000000, 8'b10000000, 20, 3};
    vecs[22] = '{10'b0100000000, 8'b01000000, 21, 3};
    vecs[23] = '{10'b0001001000, 8'b00000100, 22, 3};
    vecs[24] = '{10'b1100000000, 8'b00000010, 23, 4};
    vecs[25] = '{10'b1100000000, 8'b00000010, 23, 4};

    apply(10'b0);
    #2;
    chk("reset_outs", outs, 8'h00);
    chk("reset_cycle", cycle_cnt, 0);
    chk("reset_code", err_code, 0);

    // ALU, store, stalled load, then ebreak into HALT
    do_reset();
    for (int i = 0; i < 26; i++) begin
      apply(vecs[i].in_bits);
      @(negedge clk);
      chk($sformatf("vec%0d_outs", i), outs, vecs[i].exp_outs);
      chk($sformatf("vec%0d_cycle", i), cycle_cnt, vecs[i].exp_cyc);
      chk($sformatf("vec%0d_instret", i), instret_cnt, vecs[i].exp_ins);
      tick();
    end

    // Fetch request held off 5 cycles
    do_reset();
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_outs", k), outs, 8'b10000000);
      tick();
    end
    apply(10'b1000000000);
    @(negedge clk);
    chk("stall_accept", outs, 8'b10000000);
    tick();
    apply(10'b0100000000);
    @(negedge clk);
    chk("stall_irwen", outs, 8'b01000000);
    tick();

    // Handshake on the last allowed wait cycle beats the timeout
    do_reset();
    tick();
    for (int k = 0; k < 7; k++) tick();
    apply(10'b1000000000);
    tick();
    apply(10'b0100000000);
    @(negedge clk);
    chk("tmo_edge_hs_wins", outs, 8'b01000000);
    chk("tmo_edge_code", err_code, 0);
    tick();

    // No fetch response: ERROR after 8 cycles in FETCH_WAIT
    do_reset();
    tick();
    apply(10'b1000000000);
    tick();
    apply(10'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("tmo_wait%0d", k), outs, 8'h00);
      tick();
    end
    @(negedge clk);
    chk("tmo_err", outs, 8'b00000001);
    chk("tmo_code", err_code, 3);
    tick();
    tick();
    @(negedge clk);
    chk("tmo_cycle_frozen", cycle_cnt, 9);

    // Fetch bus error
    do_reset();
    tick();
    apply(10'b1000000000);
    tick();
    apply(10'b0110000000);
    @(negedge clk);
    chk("ferr_no_irwen", outs, 8'h00);
    tick();
    apply(10'b0);
    @(negedge clk);
    chk("ferr_err", outs, 8'b00000001);
    chk("ferr_code", err_code, 1);

    // LSU bus error, then asynchronous reset clears the sticky code
    do_reset();
    tick();
    apply(10'b1000000000); tick();
    apply(10'b0100000000); tick();
    apply(10'b0001000000); tick();
    apply(10'b0001000100); tick();
    apply(10'b0001000011);
    tick();
    apply(10'b0);
    @(negedge clk);
    chk("lerr_err", outs, 8'b00000001);
    chk("lerr_code", err_code, 2);
    rst = 1'b1;
    #1;
    chk("lerr_rst_code", err_code, 0);
    chk("lerr_rst_outs", outs, 8'h00);

    // Reset asserted during MEM_WAIT
    do_reset();
    tick();
    apply(10'b1000000000); tick();
    apply(10'b0100000000); tick();
    apply(10'b0000100000); tick();
    apply(10'b0000100100); tick();
    apply(10'b0);
    #2;
    chk("mrst_pre_cycle", cycle_cnt, 4);
    rst = 1'b1;
    #1;
    chk("mrst_cycle", cycle_cnt, 0);
    chk("mrst_outs", outs, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_reset_state", outs, 8'h00);
    tick();
    @(negedge clk);
    chk("mrst_fetch_req", outs, 8'b10000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
